// File: rtl/jtkiwi_vtimer_prog.sv
// Kiwi programmable raster timer: hdump/vdump counters with
// shadowed geometry registers, blanking, sync and init strobes.
`timescale 1ns/1ps
module jtkiwi_vtimer_prog #(
  parameter int W          = 9,
  parameter int HCNT_END_D = 383,
  parameter int HB_START_D = 256,
  parameter int HB_END_D   = 0,
  parameter int HS_START_D = 297,
  parameter int VCNT_END_D = 271,
  parameter int VB_START_D = 240,
  parameter int VB_END_D   = 16,
  parameter int VS_START_D = 254,
  parameter int V_START    = 8,
  parameter int HS_LEN     = 32,
  parameter int VS_LEN     = 3,
  parameter int CFG_LATCH  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pxl_cen,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_addr,
  input  logic [W-1:0] cfg_din,
  output logic [W-1:0] cfg_dout,
  output logic [W-1:0] hdump,
  output logic [W-1:0] vdump,
  output logic [W-1:0] vrender,
  output logic [W-1:0] vrender1,
  output logic         LHBL,
  output logic         LVBL,
  output logic         HS,
  output logic         VS,
  output logic         Hinit,
  output logic         Vinit,
  output logic         frame
);

  localparam int A_HEND = 0;
  localparam int A_HBS  = 1;
  localparam int A_HBE  = 2;
  localparam int A_HSS  = 3;
  localparam int A_VEND = 4;
  localparam int A_VBS  = 5;
  localparam int A_VBE  = 6;
  localparam int A_VSS  = 7;

  localparam int HCW = $clog2(HS_LEN + 1);
  localparam int VCW = $clog2(VS_LEN + 1);

  localparam logic [W-1:0]   ONE = W'(1);
  localparam logic [W-1:0]   VST = W'(V_START);
  localparam logic [HCW-1:0] HSL = HCW'(HS_LEN - 1);
  localparam logic [VCW-1:0] VSL = VCW'(VS_LEN - 1);

  function automatic logic [W-1:0] dflt(input int i);
    case (i)
      A_HEND:  dflt = W'(HCNT_END_D);
      A_HBS:   dflt = W'(HB_START_D);
      A_HBE:   dflt = W'(HB_END_D);
      A_HSS:   dflt = W'(HS_START_D);
      A_VEND:  dflt = W'(VCNT_END_D);
      A_VBS:   dflt = W'(VB_START_D);
      A_VBE:   dflt = W'(VB_END_D);
      default: dflt = W'(VS_START_D);
    endcase
  endfunction

  // Cyclic [s,e) membership; s == e means never inside
  function automatic logic in_rng(
    input logic [W-1:0] x,
    input logic [W-1:0] s,
    input logic [W-1:0] e
  );
    if (s < e)      in_rng = (x >= s) && (x < e);
    else if (s > e) in_rng = (x >= s) || (x < e);
    else            in_rng = 1'b0;
  endfunction

  logic [W-1:0]   shd_q [8];
  logic [W-1:0]   act_q [8];
  logic [W-1:0]   act_d [8];
  logic [W-1:0]   hdump_q, hdump_d;
  logic [W-1:0]   vdump_q, vdump_d;
  logic [W-1:0]   vr_q, vr_d;
  logic [W-1:0]   vr1_q, vr1_d;
  logic           lhbl_q, lvbl_q;
  logic           hs_q, vs_q, frame_q;
  logic [HCW-1:0] hcnt_q;
  logic [VCW-1:0] vcnt_q;
  logic           lw, fw, apply, hs_rise;

  // Wrap detection and next-state decode from the active set
  always_comb begin
    lw      = pxl_cen && (hdump_q >= act_q[A_HEND]);
    fw      = lw && ((vdump_q >= act_q[A_VEND]) || (&vdump_q));
    apply   = (CFG_LATCH != 0) ? lw : fw;
    for (int i = 0; i < 8; i++)
      act_d[i] = apply ? shd_q[i] : act_q[i];
    hdump_d = lw ? '0 : hdump_q + ONE;
    vdump_d = !lw ? vdump_q : (fw ? VST : vdump_q + ONE);
    vr_d    = (vdump_d >= act_d[A_VEND]) ? VST : vdump_d + ONE;
    vr1_d   = (vr_d >= act_d[A_VEND]) ? VST : vr_d + ONE;
    hs_rise = (hdump_d == act_d[A_HSS]);
  end

  // CPU shadow writes, independent of the pixel enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) shd_q[i] <= dflt(i);
    end else if (cfg_we) begin
      shd_q[cfg_addr] <= cfg_din;
    end
  end

  // Active set reloads from shadow at the chosen boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) act_q[i] <= dflt(i);
    end else if (apply) begin
      for (int i = 0; i < 8; i++) act_q[i] <= shd_q[i];
    end
  end

  // Counters and render lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdump_q <= '0;
      vdump_q <= VST;
      vr_q    <= VST + ONE;
      vr1_q   <= VST + ONE + ONE;
      frame_q <= 1'b0;
    end else if (pxl_cen) begin
      hdump_q <= hdump_d;
      if (lw) begin
        vdump_q <= vdump_d;
        vr_q    <= vr_d;
        vr1_q   <= vr1_d;
      end
      if (fw) frame_q <= ~frame_q;
    end
  end

  // Blanking and sync, aligned with the counter values they follow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhbl_q <= 1'b1;
      lvbl_q <= 1'b1;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (pxl_cen) begin
      lhbl_q <= !in_rng(hdump_d, act_d[A_HBS], act_d[A_HBE]);
      lvbl_q <= !in_rng(vdump_d, act_d[A_VBS], act_d[A_VBE]);
      if (hs_rise) begin
        hs_q   <= 1'b1;
        hcnt_q <= HSL;
        if (vdump_d == act_d[A_VSS]) begin
          vs_q   <= 1'b1;
          vcnt_q <= VSL;
        end else if (vs_q) begin
          if (vcnt_q == '0) vs_q <= 1'b0;
          else vcnt_q <= vcnt_q - 1'b1;
        end
      end else if (hs_q) begin
        if (hcnt_q == '0) hs_q <= 1'b0;
        else hcnt_q <= hcnt_q - 1'b1;
      end
    end
  end

  assign cfg_dout = shd_q[cfg_addr];
  assign hdump    = hdump_q;
  assign vdump    = vdump_q;
  assign vrender  = vr_q;
  assign vrender1 = vr1_q;
  assign LHBL     = lhbl_q;
  assign LVBL     = lvbl_q;
  assign HS       = hs_q;
  assign VS       = vs_q;
  assign Hinit    = lw;
  assign Vinit    = fw;
  assign frame    = frame_q;

endmodule

// File: tb/tb_jtkiwi_vtimer_prog.sv
// Directed bench for jtkiwi_vtimer_prog: a line-latched instance
// with default geometry and a frame-latched small-geometry instance.
`timescale 1ns/1ps
module tb_jtkiwi_vtimer_prog;

  localparam int W = 9;

  logic clk, rst_n;
  logic cen_l, cen_f, we_l, we_f;
  logic [2:0] addr;
  logic [W-1:0] din;

  logic [W-1:0] dout_l, hd_l, vd_l, vr_l, vr1_l;
  logic lhbl_l, lvbl_l, hs_l, vs_l, hi_l, vi_l, fr_l;
  logic [W-1:0] dout_f, hd_f, vd_f, vr_f, vr1_f;
  logic lhbl_f, lvbl_f, hs_f, vs_f, hi_f, vi_f, fr_f;

  int nvec = 0;
  int nerr = 0;

  jtkiwi_vtimer_prog #(.W(W), .CFG_LATCH(1)) u_l (
    .clk(clk), .rst_n(rst_n), .pxl_cen(cen_l),
    .cfg_we(we_l), .cfg_addr(addr), .cfg_din(din),
    .cfg_dout(dout_l), .hdump(hd_l), .vdump(vd_l),
    .vrender(vr_l), .vrender1(vr1_l),
    .LHBL(lhbl_l), .LVBL(lvbl_l), .HS(hs_l), .VS(vs_l),
    .Hinit(hi_l), .Vinit(vi_l), .frame(fr_l)
  );

  jtkiwi_vtimer_prog #(
    .W(W), .HCNT_END_D(15), .HB_START_D(12), .HB_END_D(2),
    .HS_START_D(5), .VCNT_END_D(19), .VB_START_D(18),
    .VB_END_D(10), .VS_START_D(16), .V_START(8),
    .HS_LEN(4), .VS_LEN(2), .CFG_LATCH(0)
  ) u_f (
    .clk(clk), .rst_n(rst_n), .pxl_cen(cen_f),
    .cfg_we(we_f), .cfg_addr(addr), .cfg_din(din),
    .cfg_dout(dout_f), .hdump(hd_f), .vdump(vd_f),
    .vrender(vr_f), .vrender1(vr1_f),
    .LHBL(lhbl_f), .LVBL(lvbl_f), .HS(hs_f), .VS(vs_f),
    .Hinit(hi_f), .Vinit(vi_f), .frame(fr_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix_l(input int n);
    repeat (n) begin
      cen_l = 1'b1;
      tick();
      cen_l = 1'b0;
      tick();
    end
  endtask

  task automatic run_l(input int n);
    cen_l = 1'b1;
    repeat (n) tick();
    cen_l = 1'b0;
  endtask

  task automatic run_f(input int n);
    cen_f = 1'b1;
    repeat (n) tick();
    cen_f = 1'b0;
  endtask

  task automatic wr_l(input logic [2:0] a, input logic [W-1:0] d);
    addr = a; din = d; we_l = 1'b1;
    tick();
    we_l = 1'b0;
  endtask

  task automatic wr_f(input logic [2:0] a, input logic [W-1:0] d);
    addr = a; din = d; we_f = 1'b1;
    tick();
    we_f = 1'b0;
  endtask

  int nlb, nhs, nhi, hsfirst;

  initial begin
    rst_n = 1'b0; cen_l = 1'b0; cen_f = 1'b0;
    we_l = 1'b0; we_f = 1'b0; addr = '0; din = '0;
    repeat (3) tick();
    chk("rst_hdump", hd_l, 0);
    chk("rst_vdump", vd_l, 8);
    chk("rst_vrender", vr_l, 9);
    chk("rst_vrender1", vr1_l, 10);
    chk("rst_lhbl", lhbl_l, 1);
    chk("rst_lvbl", lvbl_l, 1);
    chk("rst_hs", hs_l, 0);
    chk("rst_vs", vs_l, 0);
    chk("rst_frame", fr_l, 0);
    chk("rst_dout", dout_l, 383);
    chk("rst_f_vdump", vd_f, 8);
    chk("rst_f_dout", dout_f, 15);
    rst_n = 1'b1;
    tick(); tick();
    chk("hold_no_cen", hd_l, 0);

    pix_l(1);
    chk("first_cen_hdump", hd_l, 1);
    chk("first_cen_lvbl", lvbl_l, 0);
    chk("first_cen_lhbl", lhbl_l, 1);
    pix_l(382);
    chk("hdump_383", hd_l, 383);
    chk("lhbl_383", lhbl_l, 0);
    cen_l = 1'b1; #1;
    chk("hinit_wrap", hi_l, 1);
    chk("vinit_nowrap", vi_l, 0);
    @(posedge clk); #1; cen_l = 1'b0;
    chk("wrap_hdump", hd_l, 0);
    chk("wrap_vdump", vd_l, 9);
    chk("wrap_vrender", vr_l, 10);
    chk("wrap_vrender1", vr1_l, 11);
    chk("wrap_lhbl", lhbl_l, 1);
    tick();

    nlb = 0; nhs = 0; nhi = 0; hsfirst = -1;
    for (int i = 0; i < 384; i++) begin
      cen_l = 1'b1; #1;
      if (hi_l) nhi++;
      @(posedge clk); #1; cen_l = 1'b0;
      if (!lhbl_l) nlb++;
      if (hs_l) begin
        nhs++;
        if (hsfirst < 0) hsfirst = int'(hd_l);
      end
      tick();
    end
    chk("line_hinit_cnt", nhi, 1);
    chk("line_lhbl_low", nlb, 128);
    chk("line_hs_width", nhs, 32);
    chk("line_hs_start", hsfirst, 297);
    chk("line_end_hdump", hd_l, 0);
    chk("line_end_vdump", vd_l, 10);

    pix_l(300);
    chk("ll_at300", hd_l, 300);
    wr_l(3'd0, 9'd199);
    chk("ll_dout", dout_l, 199);
    pix_l(83);
    chk("ll_old_end", hd_l, 383);
    chk("ll_old_vd", vd_l, 10);
    pix_l(1);
    chk("ll_wrap_hd", hd_l, 0);
    chk("ll_wrap_vd", vd_l, 11);
    pix_l(199);
    chk("ll_new_199", hd_l, 199);
    pix_l(1);
    chk("ll_new_wrap_hd", hd_l, 0);
    chk("ll_new_wrap_vd", vd_l, 12);

    wr_l(3'd0, 9'd47);
    wr_l(3'd1, 9'd32);
    wr_l(3'd2, 9'd8);
    wr_l(3'd3, 9'd4);
    run_l(200);
    chk("sm_hd", hd_l, 0);
    chk("sm_vd", vd_l, 13);
    chk("sm_lhbl_cyc", lhbl_l, 0);
    chk("sm_lvbl13", lvbl_l, 0);
    run_l(3 * 48);
    chk("vb_end_vd", vd_l, 16);
    chk("vb_end_lvbl", lvbl_l, 1);
    run_l(238 * 48);
    chk("vs_line_vd", vd_l, 254);
    chk("vs_pre", vs_l, 0);
    run_l(4);
    chk("vs_hs_rise", hs_l, 1);
    chk("vs_rise", vs_l, 1);
    chk("vs_lvbl", lvbl_l, 0);
    chk("vs_vrender", vr_l, 255);
    chk("vs_vrender1", vr1_l, 256);
    run_l(96);
    chk("vs_256", vs_l, 1);
    run_l(48);
    chk("vs_257_vd", vd_l, 257);
    chk("vs_257_fall", vs_l, 0);
    chk("vs_257_hs", hs_l, 1);
    run_l(13 * 48);
    chk("vr_270", vr_l, 271);
    chk("vr1_270", vr1_l, 8);
    run_l(48);
    chk("vr_271", vr_l, 8);
    chk("vr1_271", vr1_l, 9);
    run_l(43);
    chk("fw_pre_hd", hd_l, 47);
    cen_l = 1'b1; #1;
    chk("fw_hinit", hi_l, 1);
    chk("fw_vinit", vi_l, 1);
    @(posedge clk); #1; cen_l = 1'b0;
    chk("fw_vd", vd_l, 8);
    chk("fw_hd", hd_l, 0);
    chk("fw_frame", fr_l, 1);
    chk("fw_lvbl", lvbl_l, 0);

    run_l(252 * 48);
    chk("sh_vd260", vd_l, 260);
    wr_l(3'd4, 9'd250);
    run_l(47);
    chk("sh_hd47", hd_l, 47);
    run_l(1);
    chk("sh_vd261", vd_l, 261);
    chk("sh_frame", fr_l, 1);
    chk("sh_vrender", vr_l, 8);
    run_l(47);
    cen_l = 1'b1; #1;
    chk("sh_vinit", vi_l, 1);
    @(posedge clk); #1; cen_l = 1'b0;
    chk("sh_vd", vd_l, 8);
    chk("sh_frame_tog", fr_l, 0);

    run_f(64);
    chk("f_vd12", vd_f, 12);
    chk("f_hd0", hd_f, 0);
    wr_f(3'd0, 9'd9);
    chk("f_dout", dout_f, 9);
    run_f(16);
    chk("f_len_kept_vd", vd_f, 13);
    chk("f_len_kept_hd", hd_f, 0);
    run_f(111);
    chk("f_end_vd", vd_f, 19);
    chk("f_end_hd", hd_f, 15);
    cen_f = 1'b1; #1;
    chk("f_vinit", vi_f, 1);
    @(posedge clk); #1; cen_f = 1'b0;
    chk("f_fw_vd", vd_f, 8);
    chk("f_fw_frame", fr_f, 1);
    run_f(9);
    chk("f_new_hd9", hd_f, 9);
    run_f(1);
    chk("f_new_wrap_hd", hd_f, 0);
    chk("f_new_wrap_vd", vd_f, 9);

    run_f(109);
    chk("sim_pre_vd", vd_f, 19);
    chk("sim_pre_hd", hd_f, 9);
    addr = 3'd4; din = 9'd13; we_f = 1'b1; cen_f = 1'b1; #1;
    chk("sim_vinit", vi_f, 1);
    @(posedge clk); #1; cen_f = 1'b0; we_f = 1'b0;
    chk("sim_vd", vd_f, 8);
    chk("sim_frame", fr_f, 0);
    chk("sim_dout", dout_f, 13);
    run_f(119);
    chk("sim_old_vd", vd_f, 19);
    chk("sim_old_hd", hd_f, 9);
    cen_f = 1'b1; #1;
    chk("sim_old_vinit", vi_f, 1);
    @(posedge clk); #1; cen_f = 1'b0;
    chk("sim_old_wrap", vd_f, 8);
    chk("sim_old_frame", fr_f, 1);
    run_f(59);
    chk("sim_new_vd", vd_f, 13);
    cen_f = 1'b1; #1;
    chk("sim_new_vinit", vi_f, 1);
    @(posedge clk); #1; cen_f = 1'b0;
    chk("sim_new_wrap", vd_f, 8);
    chk("sim_new_frame", fr_f, 0);

    run_f(25);
    chk("mr_vd", vd_f, 10);
    chk("mr_hd", hd_f, 5);
    wr_f(3'd0, 9'd3);
    chk("mr_pend", dout_f, 3);
    rst_n = 1'b0; #1;
    chk("mr_vd8", vd_f, 8);
    chk("mr_hd0", hd_f, 0);
    chk("mr_frame", fr_f, 0);
    chk("mr_dout", dout_f, 15);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/jtkiwi_vtimer_prog.md
# jtkiwi_vtimer_prog

Programmable raster timing generator for the Kiwi video subsystem. It replaces the fixed-parameter timer feeding gfx and colmix with counters whose line and frame geometry can be reloaded at run time. CPU writes land in shadow registers and take effect only at a line or frame boundary. It produces dump and render counters, blanking, sync and init strobes for tilemap, object and colour-mix blocks.

## Interface
Parameters:
- W, 9, width of all counters and timing registers
- HCNT_END_D, 383, reset value of last hdump count (line = HCNT_END+1 pixels)
- HB_START_D, 256, reset value of first blanked hdump
- HB_END_D, 0, reset value of first visible hdump
- HS_START_D, 297, reset value of HS rising hdump
- VCNT_END_D, 271, reset value of last vdump count
- VB_START_D, 240, reset value of first blanked line
- VB_END_D, 16, reset value of first visible line
- VS_START_D, 254, reset value of VS line
- V_START, 8, first vdump value of a frame (not programmable)
- HS_LEN, 32, HS width in pixels
- VS_LEN, 3, VS width in lines
- CFG_LATCH, 0, 0 = shadow applied at frame wrap, 1 = at every line wrap

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- pxl_cen  in  1  pixel clock enable
- cfg_we  in  1  shadow register write strobe
- cfg_addr  in  3  register index: 0 HCNT_END, 1 HB_START, 2 HB_END, 3 HS_START, 4 VCNT_END, 5 VB_START, 6 VB_END, 7 VS_START
- cfg_din  in  W  write data
- cfg_dout  out  W  shadow register at cfg_addr (combinational)
- hdump  out  W  horizontal position
- vdump  out  W  current line
- vrender  out  W  next line
- vrender1  out  W  line after next
- LHBL  out  1  low during horizontal blanking
- LVBL  out  1  low during vertical blanking
- HS  out  1  horizontal sync, active high
- VS  out  1  vertical sync, active high
- Hinit  out  1  line wrap strobe
- Vinit  out  1  frame wrap strobe
- frame  out  1  toggles every frame

## Operation
- Two register sets, shadow and active, eight W-bit entries each. Both reset to the *_D values. cfg_we writes shadow[cfg_addr] on any clk, independent of pxl_cen. Counters and decodes use active only.
- Line wrap (LW): pxl_cen while hdump >= HCNT_END. Frame wrap (FW): LW while vdump >= VCNT_END, or LW while vdump is all-ones. The >= comparisons keep counters bounded after a shrink.
- On pxl_cen: hdump <= LW ? 0 : hdump+1.
- On LW: vdump <= FW ? V_START : vdump+1.
- vrender = vdump+1 and vrender1 = vdump+2, each wrapping to V_START past active VCNT_END. Both are registered and update together with vdump.
- Apply: on FW (CFG_LATCH=0) or LW (CFG_LATCH=1), active <= shadow. A shadow write in the same clk as apply is not applied; it waits for the next boundary.
- LHBL = 0 for hdump in the cyclic range [HB_START, HB_END). LVBL = 0 for vdump in the cyclic range [VB_START, VB_END). If start equals end, the signal is constantly 1.
- HS rises at the pxl_cen loading hdump = HS_START and stays high HS_LEN pixels; a pulse running past a line wrap continues. VS rises with HS on line VS_START and falls with HS rising VS_LEN lines later.
- Hinit = LW and Vinit = FW; each is high one clk, coincident with the wrapping pxl_cen. frame toggles on FW.

## Timing
- Reset (asynchronous, rst_n low):
  - hdump = 0, vdump = V_START, vrender = V_START+1, vrender1 = V_START+2.
  - LHBL = 1, LVBL = 1, HS = 0, VS = 0, frame = 0.
  - active = shadow = defaults.
- After reset, the first pxl_cen gives hdump = 1.
- All outputs except cfg_dout, Hinit and Vinit are registered and change only on a clk with pxl_cen = 1. Without pxl_cen the state holds.
- LHBL, LVBL and HS are decoded from the next counter values, so they are aligned with hdump/vdump with zero latency.
- Default geometry: 384 pixels per line, 264 lines per frame (8..271), 101376 pixel cens per frame.
- rst_n asserted mid-frame aborts immediately. Any pending shadow writes are discarded.

## Test plan
- Reset: hold rst_n low, then release -> hdump=0, vdump=8, LHBL=LVBL=1, HS=VS=0; first pxl_cen gives hdump=1.
- Default free run, pxl_cen every 2nd clk:
  - Hinit period is 384 cens; Vinit period is 101376 cens.
  - LHBL is low for 128 cens per line; LVBL is low on lines 240..271 and 8..15.
  - HS is 32 cens wide at hdump 297; VS covers 3 lines starting at line 254.
- Frame latch: at vdump=100, write HCNT_END=255 -> line length stays 384 until Vinit, then 256; cfg_dout reads 255 immediately.
- Line latch (CFG_LATCH=1): at hdump=300, write HCNT_END=199 -> current line ends at 383; the next line is 200 pixels.
- Shrink while counting (CFG_LATCH=1): at vdump=260, write VCNT_END=250 -> after the next LW, vdump >= VCNT_END triggers FW; vdump=V_START and frame toggles.
- Simultaneous write and FW in the same clk -> the old value is used for the next frame, the new value one frame later; mid-frame reset restores vdump=8.
